// File: rtl/bus_keyboard_fifo_controller.sv
// Buffered PS/2 keyboard controller on the ECO32 I/O bus: deserialises device-to-host frames,
// checks framing/parity and queues received bytes in a FIFO read through a small register set.
module bus_keyboard_fifo_controller #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       busEnable,
    input  logic       busWrite,
    input  logic [3:2] busAddress,
    input  logic [7:0] busWriteData,
    output logic [7:0] busReadData,
    output logic       busWait,
    output logic       interrupt,
    input  logic       ps2Clock,
    input  logic       ps2Data
);

    localparam int unsigned Depth      = 2 ** FIFO_DEPTH_LOG2;
    localparam int unsigned CountWidth = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rxState_e;

    logic [1:0] clockSync, dataSync;
    logic       clockPrev, fallEdge, edgeData;

    rxState_e   state, stateNext;
    logic [7:0] shiftReg, shiftNext;
    logic [2:0] bitCount, bitCountNext;
    logic       parityBit, parityNext;
    logic       pushReq, pushNext;
    logic       rxError, timeoutHit;
    logic [TimerWidth-1:0] timer;

    logic [7:0]                 mem [Depth];
    logic [FIFO_DEPTH_LOG2-1:0] wrPtr, rdPtr;
    logic [CountWidth-1:0]      count;
    logic [7:0]                 countWide, effThreshold, threshold;
    logic                       interruptEnable, overrun, frameError;
    logic                       notEmpty, full, ctrlWrite, threshWrite, pop, push, flush, overrunSet;
    logic                       unusedBits;

    // Edge is registered once more so the data sample lines up with it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clockSync <= 2'b00;
            dataSync  <= 2'b00;
            clockPrev <= 1'b0;
            fallEdge  <= 1'b0;
            edgeData  <= 1'b0;
        end else begin
            clockSync <= {clockSync[0], ps2Clock};
            dataSync  <= {dataSync[0], ps2Data};
            clockPrev <= clockSync[1];
            fallEdge  <= clockPrev & ~clockSync[1];
            edgeData  <= dataSync[1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (fallEdge || state == StIdle) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign timeoutHit = (state != StIdle) && !fallEdge &&
                        (timer == TimerWidth'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            shiftReg  <= 8'h00;
            bitCount  <= 3'd0;
            parityBit <= 1'b0;
            pushReq   <= 1'b0;
        end else begin
            state     <= stateNext;
            shiftReg  <= shiftNext;
            bitCount  <= bitCountNext;
            parityBit <= parityNext;
            pushReq   <= pushNext;
        end
    end

    always_comb begin
        stateNext    = state;
        shiftNext    = shiftReg;
        bitCountNext = bitCount;
        parityNext   = parityBit;
        pushNext     = 1'b0;
        rxError      = 1'b0;
        if (fallEdge) begin
            case (state)
                StIdle: begin
                    if (!edgeData) begin
                        stateNext    = StData;
                        bitCountNext = 3'd0;
                    end
                end
                StData: begin
                    shiftNext    = {edgeData, shiftReg[7:1]};
                    bitCountNext = bitCount + 3'd1;
                    if (bitCount == 3'd7) stateNext = StParity;
                end
                StParity: begin
                    parityNext = edgeData;
                    stateNext  = StStop;
                end
                default: begin
                    // Odd parity across data plus parity bit, stop bit must be high.
                    if (edgeData && (^{shiftReg, parityBit})) pushNext = 1'b1;
                    else                                     rxError  = 1'b1;
                    stateNext = StIdle;
                end
            endcase
        end else if (timeoutHit) begin
            stateNext = StIdle;
            rxError   = 1'b1;
        end
    end

    assign notEmpty    = (count != '0);
    assign full        = (count == CountWidth'(Depth));
    assign ctrlWrite   = busEnable && busWrite && (busAddress == 2'd0);
    assign threshWrite = busEnable && busWrite && (busAddress == 2'd3);
    assign pop         = busEnable && !busWrite && (busAddress == 2'd1) && notEmpty;
    assign flush       = ctrlWrite && busWriteData[4];
    assign push        = pushReq && !flush && (!full || pop);
    assign overrunSet  = pushReq && !flush && full && !pop;
    assign unusedBits  = ^{busWriteData[7:5], busWriteData[0]};

    always_ff @(posedge clock) begin
        if (push) mem[wrPtr] <= shiftReg;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= wrPtr;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // A set event in the same cycle as its clear keeps the flag high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            interruptEnable <= 1'b0;
            overrun         <= 1'b0;
            frameError      <= 1'b0;
            threshold       <= 8'd1;
        end else begin
            if (ctrlWrite)   interruptEnable <= busWriteData[1];
            if (threshWrite) threshold       <= busWriteData;
            overrun    <= overrunSet | (overrun & ~(ctrlWrite & busWriteData[2]));
            frameError <= rxError | (frameError & ~(ctrlWrite & busWriteData[3]));
        end
    end

    assign countWide    = 8'(count);
    assign effThreshold = (threshold == 8'd0) ? 8'd1 : threshold;
    assign interrupt    = interruptEnable &
                          ((countWide >= effThreshold) | overrun | frameError);
    assign busWait      = 1'b0;

    always_comb begin
        busReadData = 8'h00;
        case (busAddress)
            2'd0:    busReadData = {4'b0000, frameError, overrun, interruptEnable, notEmpty};
            2'd1:    busReadData = notEmpty ? mem[rdPtr] : 8'h00;
            2'd2:    busReadData = countWide;
            default: busReadData = threshold;
        endcase
    end

endmodule

// File: tb/tb_bus_keyboard_fifo_controller.sv
// Self-checking bench for bus_keyboard_fifo_controller: directed vector table, hand-timed
// corner sequences and random traffic against a queue-based reference model.
module tb_bus_keyboard_fifo_controller;

    localparam int L2    = 4;
    localparam int Depth = 16;
    localparam int Tmo   = 1000;
    localparam int Half  = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       busEnable = 1'b0;
    logic       busWrite = 1'b0;
    logic [1:0] busAddress = 2'd0;
    logic [7:0] busWriteData = 8'h00;
    logic [7:0] busReadData;
    logic       busWait;
    logic       interrupt;
    logic       ps2Clock = 1'b1;
    logic       ps2Data = 1'b1;

    bus_keyboard_fifo_controller #(
        .FIFO_DEPTH_LOG2(L2),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .busEnable   (busEnable),
        .busWrite    (busWrite),
        .busAddress  (busAddress),
        .busWriteData(busWriteData),
        .busReadData (busReadData),
        .busWait     (busWait),
        .interrupt   (interrupt),
        .ps2Clock    (ps2Clock),
        .ps2Data     (ps2Data)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0] mq[$];
    logic       mIe, mOvr, mFe;
    logic [7:0] mThr;

    typedef struct {
        logic [7:0] data;
        logic       badPar;
        logic       stop;
        int         expCount;
        logic       expFe;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mIe = 1'b0; mOvr = 1'b0; mFe = 1'b0; mThr = 8'd1;
    endtask

    function automatic logic expInt();
        int eff;
        eff = (mThr == 8'd0) ? 1 : int'(mThr);
        return mIe && ((mq.size() >= eff) || mOvr || mFe);
    endfunction

    task automatic busRd(input logic [1:0] a, output logic [7:0] d);
        @(negedge clock);
        busEnable = 1'b1; busWrite = 1'b0; busAddress = a;
        #1 d = busReadData;
        @(negedge clock);
        busEnable = 1'b0;
    endtask

    task automatic busWr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clock);
        busEnable = 1'b1; busWrite = 1'b1; busAddress = a; busWriteData = d;
        @(negedge clock);
        busEnable = 1'b0; busWrite = 1'b0;
    endtask

    task automatic ctrlWrite(input logic [7:0] d);
        busWr(2'd0, d);
        mIe = d[1];
        if (d[2]) mOvr = 1'b0;
        if (d[3]) mFe = 1'b0;
        if (d[4]) mq.delete();
    endtask

    task automatic threshWrite(input logic [7:0] d);
        busWr(2'd3, d);
        mThr = d;
    endtask

    task automatic dataRead(input string name, output logic [7:0] d);
        logic [7:0] e;
        busRd(2'd1, d);
        e = 8'h00;
        if (mq.size() != 0) e = mq.pop_front();
        check(name, d, e);
    endtask

    task automatic checkAll(input string tag);
        logic [7:0] c, n, t;
        busRd(2'd0, c);
        check({tag, ".ctrl"}, c, {4'b0, mFe, mOvr, mIe, mq.size() != 0});
        busRd(2'd2, n);
        check({tag, ".count"}, n, mq.size());
        busRd(2'd3, t);
        check({tag, ".thresh"}, t, mThr);
        check({tag, ".irq"}, interrupt, expInt());
    endtask

    task automatic ps2Bit(input logic b);
        @(negedge clock);
        ps2Data = b;
        repeat (Half) @(negedge clock);
        ps2Clock = 1'b0;
        repeat (Half) @(negedge clock);
        ps2Clock = 1'b1;
    endtask

    function automatic logic [10:0] frameBits(input logic [7:0] b, input logic badPar,
                                              input logic stop);
        return {stop, (~^b) ^ badPar, b, 1'b0};
    endfunction

    task automatic sendRaw(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) ps2Bit(bits[i]);
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic badPar, input logic stop);
        sendRaw(frameBits(b, badPar, stop), 11);
        repeat (8) @(negedge clock);
        if (!badPar && stop) begin
            if (mq.size() == Depth) mOvr = 1'b1;
            else                    mq.push_back(b);
        end else begin
            mFe = 1'b1;
        end
    endtask

    // Valid frame whose FIFO push lands in the same cycle as a bus access: the push takes
    // effect on the 5th rising edge after the final PS/2 falling edge.
    task automatic coincide(input logic [7:0] b, input logic doRead, input logic [7:0] ctrl,
                            output logic [7:0] rd);
        sendRaw(frameBits(b, 1'b0, 1'b1), 10);
        @(negedge clock);
        ps2Data = 1'b1;
        repeat (Half) @(negedge clock);
        ps2Clock = 1'b0;
        repeat (3) @(negedge clock);
        rd = 8'h00;
        if (doRead) busRd(2'd1, rd);
        else        busWr(2'd0, ctrl);
        repeat (Half) @(negedge clock);
        ps2Clock = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[6];
        logic [7:0] expReads[5];
        logic [7:0] rd, c, n;
        int         op;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 1'b0};
        vecs[1] = '{8'hF0, 1'b0, 1'b1, 2, 1'b0};
        vecs[2] = '{8'h1C, 1'b1, 1'b1, 2, 1'b1};
        vecs[3] = '{8'hAA, 1'b0, 1'b0, 2, 1'b1};
        vecs[4] = '{8'h00, 1'b0, 1'b1, 3, 1'b1};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, 4, 1'b1};
        expReads = '{8'h1C, 8'hF0, 8'h00, 8'hFF, 8'h00};

        // Reset values.
        repeat (3) @(negedge clock);
        check("rst.irq_during", interrupt, 1'b0);
        check("rst.wait_during", busWait, 1'b0);
        reset = 1'b1;
        modelReset();
        checkAll("rst");
        check("rst.wait", busWait, 1'b0);

        // Directed frame table.
        for (int i = 0; i < 6; i++) begin
            sendFrame(vecs[i].data, vecs[i].badPar, vecs[i].stop);
            busRd(2'd2, n);
            check($sformatf("vec%0d.count", i), n, vecs[i].expCount);
            busRd(2'd0, c);
            check($sformatf("vec%0d.fe", i), c[3], vecs[i].expFe);
            check($sformatf("vec%0d.notEmpty", i), c[0], 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            dataRead($sformatf("vec.read%0d", i), rd);
            check($sformatf("vec.readConst%0d", i), rd, expReads[i]);
        end
        checkAll("vec.after");
        ctrlWrite(8'h08);
        checkAll("vec.feClear");

        // Reset asserted mid-frame, then a clean frame.
        sendRaw(frameBits(8'h96, 1'b0, 1'b1), 5);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("midrst.irq", interrupt, 1'b0);
        reset = 1'b1;
        modelReset();
        sendFrame(8'h5A, 1'b0, 1'b1);
        checkAll("midrst");
        dataRead("midrst.data", rd);
        check("midrst.dataConst", rd, 8'h5A);

        // Timeout on a stalled partial frame.
        sendRaw(frameBits(8'h33, 1'b0, 1'b1), 4);
        checkAll("tmo.partial");
        repeat (Tmo + 20) @(negedge clock);
        busRd(2'd0, c);
        check("tmo.fe", c[3], 1'b1);
        mFe = 1'b1;
        sendFrame(8'h3C, 1'b0, 1'b1);
        dataRead("tmo.next", rd);
        check("tmo.nextConst", rd, 8'h3C);
        ctrlWrite(8'h08);

        // Overrun on a full FIFO, then push coinciding with pop and with flush.
        ctrlWrite(8'h1C);
        for (int i = 1; i <= Depth + 1; i++) sendFrame(8'(i), 1'b0, 1'b1);
        busRd(2'd2, n);
        check("ovr.count", n, Depth);
        busRd(2'd0, c);
        check("ovr.flag", c[2], 1'b1);
        checkAll("ovr");
        dataRead("ovr.first", rd);
        check("ovr.firstConst", rd, 8'h01);
        sendFrame(8'h40, 1'b0, 1'b1);
        ctrlWrite(8'h04);
        coincide(8'h41, 1'b1, 8'h00, rd);
        check("pushpop.data", rd, 8'h02);
        void'(mq.pop_front());
        mq.push_back(8'h41);
        busRd(2'd2, n);
        check("pushpop.count", n, Depth);
        checkAll("pushpop");
        coincide(8'h42, 1'b0, 8'h10, rd);
        mq.delete();
        busRd(2'd2, n);
        check("flushpush.count", n, 0);
        checkAll("flushpush");

        // Interrupt threshold.
        ctrlWrite(8'h02);
        threshWrite(8'd3);
        sendFrame(8'h11, 1'b0, 1'b1);
        sendFrame(8'h22, 1'b0, 1'b1);
        check("thr.two", interrupt, 1'b0);
        sendFrame(8'h33, 1'b0, 1'b1);
        check("thr.three", interrupt, 1'b1);
        dataRead("thr.read1", rd);
        check("thr.afterRead", interrupt, 1'b0);
        dataRead("thr.read2", rd);
        threshWrite(8'd0);
        check("thr.zero", interrupt, 1'b1);
        threshWrite(8'd20);
        check("thr.aboveDepth", interrupt, 1'b0);
        checkAll("thr");

        // Flush with five queued bytes.
        ctrlWrite(8'h10);
        for (int i = 0; i < 5; i++) sendFrame(8'hA0 + 8'(i), 1'b0, 1'b1);
        checkAll("flush.pre");
        ctrlWrite(8'h10);
        busRd(2'd0, c);
        check("flush.notEmpty", c[0], 1'b0);
        checkAll("flush");

        // Random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1: sendFrame(8'($urandom), 1'b0, 1'b1);
                2: begin
                    logic bp;
                    bp = 1'($urandom);
                    sendFrame(8'($urandom), bp, bp ? 1'($urandom) : 1'b0);
                end
                3: dataRead($sformatf("rnd%0d.data", i), rd);
                4: ctrlWrite((8'($urandom) & 8'h0E) |
                             (($urandom_range(0, 7) == 0) ? 8'h10 : 8'h00));
                default: threshWrite(8'($urandom_range(0, 20)));
            endcase
            checkAll($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
